// File: rtl/ram_dp_loader.sv
// Dual-port 32-bit RAM: byte-enabled data port A, halfword instruction port B,
// plus an optional byte-stream boot loader enabled by defining RAM_DP_LOADER_EN.
module ram_dp_loader #(
    parameter int WORDS     = 4096,
    parameter     INIT_FILE = "",
    localparam int AB       = $clog2(WORDS) + 2
) (
    input  logic          clk,
    input  logic          resetq,
    input  logic [AB-1:0] a_addr,
    input  logic [31:0]   a_d,
    input  logic [3:0]    a_be,
    input  logic          a_wr,
    output logic [31:0]   a_q,
    input  logic [AB-2:0] b_addr,
    output logic [15:0]   b_q,
    input  logic          ld_valid,
    input  logic [7:0]    ld_data,
    output logic          ld_ready,
    input  logic          ld_start,
    output logic          cpu_hold,
    output logic          ld_done
);

    localparam int WA = AB - 2;

    logic [31:0]   mem [WORDS];
    logic [WA-1:0] a_word_q;
    logic [WA-1:0] b_word_q;
    logic          b_half_q;

    logic          ld_we;
    logic [WA-1:0] ld_waddr;
    logic [31:0]   ld_wdata;
    logic          unused_bits;

    logic          we;
    logic [WA-1:0] waddr;
    logic [31:0]   wdata;
    logic [3:0]    wbe;

`ifdef RAM_DP_LOADER_EN
    typedef enum logic [1:0] {IDLE, HDR, DATA, FIN} state_t;

    state_t      state, state_nx;
    logic [1:0]  byte_cnt;
    logic [15:0] n_words;
    logic [15:0] word_idx;
    logic [23:0] acc;

    assign unused_bits = ^a_addr[1:0];

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nx = state;
        ld_ready = 1'b0;
        cpu_hold = 1'b1;
        ld_done  = 1'b0;
        unique case (state)
            IDLE: begin
                cpu_hold = 1'b0;
                if (ld_start) state_nx = HDR;
            end
            HDR: begin
                ld_ready = 1'b1;
                if (ld_valid && byte_cnt[0])
                    state_nx = ({ld_data, n_words[7:0]} == 16'd0) ? FIN : DATA;
            end
            DATA: begin
                ld_ready = 1'b1;
                if (ld_valid && byte_cnt == 2'd3 && word_idx == n_words - 16'd1)
                    state_nx = FIN;
            end
            FIN: begin
                ld_done  = 1'b1;
                state_nx = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetq) begin
            state    <= IDLE;
            byte_cnt <= 2'd0;
            n_words  <= 16'd0;
            word_idx <= 16'd0;
            acc      <= 24'd0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: if (ld_start) begin
                    byte_cnt <= 2'd0;
                    word_idx <= 16'd0;
                end
                HDR: if (ld_valid) begin
                    byte_cnt <= byte_cnt[0] ? 2'd0 : 2'd1;
                    if (byte_cnt[0]) n_words[15:8] <= ld_data;
                    else             n_words[7:0]  <= ld_data;
                end
                DATA: if (ld_valid) begin
                    byte_cnt <= byte_cnt + 2'd1;
                    case (byte_cnt)
                        2'd0:    acc[7:0]   <= ld_data;
                        2'd1:    acc[15:8]  <= ld_data;
                        2'd2:    acc[23:16] <= ld_data;
                        default: word_idx   <= word_idx + 16'd1;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // Index wraps modulo WORDS simply by dropping the upper bits.
    assign ld_we    = (state == DATA) && ld_valid && (byte_cnt == 2'd3);
    assign ld_waddr = word_idx[WA-1:0];
    assign ld_wdata = {ld_data, acc};
`else
    assign unused_bits = ^{a_addr[1:0], ld_valid, ld_data, ld_start};
    assign ld_ready    = 1'b0;
    assign cpu_hold    = 1'b0;
    assign ld_done     = 1'b0;
    assign ld_we       = 1'b0;
    assign ld_waddr    = '0;
    assign ld_wdata    = '0;
`endif

    always_comb begin
        we    = a_wr && !cpu_hold;
        waddr = a_addr[AB-1:2];
        wdata = a_d;
        wbe   = a_be;
        if (ld_we) begin
            we    = 1'b1;
            waddr = ld_waddr;
            wdata = ld_wdata;
            wbe   = 4'hf;
        end
    end

    // NOTE: the memory array has no reset; contents survive resetq so a reset mid-load keeps written words.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++)
                if (wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

    // Registering the addresses (not the data) makes reads write-first.
    always_ff @(posedge clk) begin
        if (!resetq) begin
            a_word_q <= '0;
            b_word_q <= '0;
            b_half_q <= 1'b0;
        end else begin
            a_word_q <= a_addr[AB-1:2];
            b_word_q <= b_addr[AB-2:1];
            b_half_q <= b_addr[0];
        end
    end

    assign a_q = mem[a_word_q];
    assign b_q = b_half_q ? mem[b_word_q][31:16] : mem[b_word_q][15:0];

endmodule

// File: tb/tb_ram_dp_loader.sv
// Scoreboard bench for ram_dp_loader: random port traffic and loader streams checked
// against an array model; expectations adapt to whether RAM_DP_LOADER_EN is defined.
`timescale 1ns/1ps
module tb_ram_dp_loader;

    localparam int WORDS = 256;
    localparam int AB    = 10;
`ifdef RAM_DP_LOADER_EN
    localparam bit LOADER = 1'b1;
`else
    localparam bit LOADER = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          resetq = 1'b0;
    logic [AB-1:0] a_addr = '0;
    logic [31:0]   a_d = '0;
    logic [3:0]    a_be = '0;
    logic          a_wr = 1'b0;
    logic [31:0]   a_q;
    logic [AB-2:0] b_addr = '0;
    logic [15:0]   b_q;
    logic          ld_valid = 1'b0;
    logic [7:0]    ld_data = '0;
    logic          ld_ready;
    logic          ld_start = 1'b0;
    logic          cpu_hold;
    logic          ld_done;

    always #5 clk = ~clk;

    ram_dp_loader #(.WORDS(WORDS)) dut (
        .clk(clk), .resetq(resetq),
        .a_addr(a_addr), .a_d(a_d), .a_be(a_be), .a_wr(a_wr), .a_q(a_q),
        .b_addr(b_addr), .b_q(b_q),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .ld_start(ld_start), .cpu_hold(cpu_hold), .ld_done(ld_done)
    );

    typedef enum int {K_AQ, K_BQ, K_HOLD, K_DONE} kind_e;
    typedef struct {
        int          due;
        kind_e       kind;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [WORDS];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          done_cnt = 0;
    bit          in_load = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void expect_next(input kind_e k, input logic [31:0] v);
        exp_t e;
        e.due  = cyc + 1;
        e.kind = k;
        e.val  = v;
        sb.push_back(e);
    endfunction

    function automatic logic [31:0] half(input int bh);
        logic [31:0] w;
        w = model[(bh / 2) % WORDS];
        return (bh % 2 == 1) ? {16'h0, w[31:16]} : {16'h0, w[15:0]};
    endfunction

    // Port-A writes land unless the loader holds the CPU.
    function automatic void apply_write(input int aw, input logic [31:0] d, input logic [3:0] be, input bit wr);
        if (wr && !(LOADER && in_load))
            for (int i = 0; i < 4; i++)
                if (be[i]) model[aw][8*i +: 8] = d[8*i +: 8];
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (ld_done) done_cnt++;
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                case (e.kind)
                    K_AQ:    check("a_q", a_q, e.val);
                    K_BQ:    check("b_q", {16'h0, b_q}, e.val);
                    K_HOLD:  check("cpu_hold", 32'(cpu_hold), e.val);
                    default: check("ld_done", 32'(ld_done), e.val);
                endcase
            end
        end
    end

    task automatic port_op(input int aw, input logic [31:0] d, input logic [3:0] be, input bit wr, input int bh);
        @(negedge clk);
        if (wr && (bh / 2) == aw) bh = bh ^ 2;
        a_addr   = AB'(aw * 4 + $urandom_range(0, 3));
        a_d      = d;
        a_be     = be;
        a_wr     = wr;
        b_addr   = (AB-1)'(bh);
        ld_start = 1'b0;
        ld_valid = 1'b0;
        apply_write(aw, d, be, wr);
        expect_next(K_AQ, model[aw]);
        expect_next(K_BQ, half(bh));
    endtask

    task automatic ld_cycle(input bit start, input bit valid, input logic [7:0] data, input int aw,
                            input bit wr, input bit exp_hold, input bit exp_done);
        logic [31:0] d;
        d = $urandom;
        @(negedge clk);
        ld_start = start;
        ld_valid = valid;
        ld_data  = data;
        a_addr   = AB'(aw * 4);
        a_d      = d;
        a_be     = 4'hf;
        a_wr     = wr;
        b_addr   = (AB-1)'(2 * aw + 1);
        apply_write(aw, d, 4'hf, wr);
        expect_next(K_AQ, model[aw]);
        expect_next(K_BQ, half(2 * aw + 1));
        expect_next(K_HOLD, 32'(exp_hold && LOADER));
        expect_next(K_DONE, 32'(exp_done && LOADER));
        if (valid) begin
            #1;
            check("ld_ready", 32'(ld_ready), 32'(LOADER));
        end
    endtask

    // stop_at < 0 sends the whole stream; otherwise reset is asserted after stop_at bytes.
    task automatic run_load(input logic [7:0] bytes[$], input int stop_at, input int aw);
        int          n, total, sent, start_done;
        logic [31:0] acc;
        acc        = '0;
        start_done = done_cnt;
        n          = int'(bytes[1]) * 256 + int'(bytes[0]);
        total      = 2 + 4 * n;
        sent       = (stop_at < 0) ? total : stop_at;
        ld_cycle(1'b1, 1'b0, 8'h00, aw, 1'b0, 1'b1, 1'b0);
        in_load = 1'b1;
        for (int i = 0; i < sent; i++) begin
            repeat ($urandom_range(0, 3))
                ld_cycle(1'($urandom_range(0, 1)), 1'b0, 8'h00, aw, 1'b1, 1'b1, 1'b0);
            if (i >= 2) begin
                acc[8*((i-2)%4) +: 8] = bytes[i];
                if ((i - 2) % 4 == 3 && LOADER) model[((i - 2) / 4) % WORDS] = acc;
            end
            ld_cycle(1'b0, 1'b1, bytes[i], aw, 1'b1, 1'b1, i == total - 1);
        end
        in_load = 1'b0;
        if (stop_at < 0) begin
            ld_cycle(1'b0, 1'b0, 8'h00, aw, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            check("ld_done pulses", 32'(done_cnt - start_done), 32'(LOADER ? 1 : 0));
        end else begin
            @(negedge clk);
            resetq   = 1'b0;
            ld_valid = 1'b0;
            ld_start = 1'b0;
            a_wr     = 1'b0;
            a_addr   = AB'(77 * 4);
            b_addr   = (AB-1)'(155);
            expect_next(K_AQ, model[0]);
            expect_next(K_BQ, half(0));
            expect_next(K_HOLD, 32'h0);
            expect_next(K_DONE, 32'h0);
            @(negedge clk);
            resetq = 1'b1;
            @(negedge clk);
            check("ld_done pulses after reset", 32'(done_cnt - start_done), 32'h0);
        end
    endtask

    initial begin : stimulus
        logic [7:0] big[$];
        repeat (3) @(negedge clk);
        check("reset cpu_hold", 32'(cpu_hold), 32'h0);
        check("reset ld_done", 32'(ld_done), 32'h0);
        check("reset ld_ready", 32'(ld_ready), 32'h0);
        resetq = 1'b1;

        for (int w = 0; w < WORDS; w++)
            port_op(w, $urandom, 4'hf, 1'b1, $urandom_range(0, 2 * WORDS - 1));

        // Partial-lane write over zero, then halfword reads of a known word.
        port_op(4, 32'h0, 4'hf, 1'b1, 0);
        port_op(4, 32'hA1B2C3D4, 4'b0101, 1'b1, 0);
        port_op(5, 32'h12345678, 4'hf, 1'b1, 0);
        port_op(0, 32'h0, 4'h0, 1'b0, 10);
        port_op(0, 32'h0, 4'h0, 1'b0, 11);

        for (int i = 0; i < 200; i++)
            port_op($urandom_range(0, 15), $urandom, 4'($urandom), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 31));

        run_load('{8'h02, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h0D, 8'hF0, 8'hFE, 8'hCA}, -1, 200);
        port_op(0, 32'h0, 4'h0, 1'b0, 1);
        port_op(1, 32'h0, 4'h0, 1'b0, 2);

        run_load('{8'h00, 8'h00}, -1, 200);
        port_op(0, 32'h0, 4'h0, 1'b0, 0);
        port_op(1, 32'h0, 4'h0, 1'b0, 3);

        // Reset after six data bytes; port-A writes to word 0 are attempted throughout.
        run_load('{8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
                   8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC}, 8, 0);
        port_op(0, 32'h0, 4'h0, 1'b0, 2);
        port_op(1, 32'h0, 4'h0, 1'b0, 0);
        port_op(2, 32'h0, 4'h0, 1'b0, 5);

        run_load('{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12}, -1, 9);
        port_op(0, 32'h0, 4'h0, 1'b0, 1);

        // More words than the memory holds: the write index wraps.
        big.push_back(8'((WORDS + 2) % 256));
        big.push_back(8'((WORDS + 2) / 256));
        for (int i = 0; i < 4 * (WORDS + 2); i++) big.push_back(8'($urandom));
        run_load(big, -1, 100);
        for (int w = 0; w < 4; w++) port_op(w, 32'h0, 4'h0, 1'b0, 2 * w + 1);
        port_op(WORDS - 1, 32'h0, 4'h0, 1'b0, 2 * WORDS - 2);

        repeat (3) @(negedge clk);
        check("scoreboard drained", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
